// File: rtl/mem_stage.sv
// Memory-access stage: launches loads/stores over a req/ack handshake, formats load
// data, and registers the write-back operands. Stalls upstream while an access is open.
module mem_stage #(
  parameter int MAX_WAIT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [31:0] in_pc4,
  input  logic [31:0] in_alu_result,
  input  logic [31:0] in_rs2_data,
  input  logic        in_mem_read,
  input  logic        in_mem_write,
  input  logic [2:0]  in_funct3,
  input  logic [1:0]  in_mem_to_reg,
  input  logic [4:0]  in_rd,
  input  logic        in_reg_write,
  output logic        stall,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        out_valid,
  output logic [31:0] out_pc4,
  output logic [31:0] out_alu_result,
  output logic [31:0] out_mem_data,
  output logic [1:0]  out_mem_to_reg,
  output logic [4:0]  out_rd,
  output logic        out_reg_write,
  output logic        out_misaligned,
  output logic        out_timeout
);
  typedef enum logic {IDLE, BUSY} state_t;

  state_t      state, state_nxt;
  logic [7:0]  cnt;
  logic [31:0] l_pc4, l_alu;
  logic [1:0]  l_m2r;
  logic [4:0]  l_rd;
  logic        l_rw, l_we;
  logic [2:0]  l_f3;

  logic        mem_op, fault, launch, expire;
  logic [1:0]  off;
  logic [3:0]  be;
  logic [31:0] wdata, load_data;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  assign mem_op = in_valid & (in_mem_read | in_mem_write);
  assign off    = in_alu_result[1:0];

  always_comb begin
    fault = 1'b0;
    case (in_funct3)
      3'b000:         fault = 1'b0;
      3'b001:         fault = off[0];
      3'b010:         fault = (off != 2'b00);
      3'b100:         fault = in_mem_write;
      3'b101:         fault = in_mem_write | off[0];
      default:        fault = 1'b1;
    endcase
  end

  always_comb begin
    be    = 4'b1111;
    wdata = in_rs2_data;
    if (in_mem_write) begin
      case (in_funct3[1:0])
        2'b00: begin be = 4'b0001 << off; wdata = {4{in_rs2_data[7:0]}};  end
        2'b01: begin be = 4'b0011 << off; wdata = {2{in_rs2_data[15:0]}}; end
        default: ;
      endcase
    end
  end

  // Load formatting uses the latched address since inputs are not trusted in BUSY.
  always_comb begin
    ld_byte = dmem_rdata[8*l_alu[1:0] +: 8];
    ld_half = dmem_rdata[16*l_alu[1] +: 16];
    case (l_f3)
      3'b000:  load_data = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  load_data = {{16{ld_half[15]}}, ld_half};
      3'b100:  load_data = {24'd0, ld_byte};
      3'b101:  load_data = {16'd0, ld_half};
      default: load_data = dmem_rdata;
    endcase
  end

  assign launch = (state == IDLE) & mem_op & ~fault;
  assign expire = (state == BUSY) & ~dmem_ack & (cnt == 8'(MAX_WAIT - 1));
  assign stall  = launch | ((state == BUSY) & ~dmem_ack & ~expire);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (launch) state_nxt = BUSY;
      BUSY:    if (dmem_ack | expire) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      {l_pc4, l_alu, l_m2r, l_rd, l_rw, l_we, l_f3} <= '0;
      {dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be} <= '0;
      {out_valid, out_pc4, out_alu_result, out_mem_data, out_mem_to_reg} <= '0;
      {out_rd, out_reg_write, out_misaligned, out_timeout} <= '0;
    end else if (state == IDLE) begin
      cnt <= '0;
      if (launch) begin
        l_pc4 <= in_pc4;  l_alu <= in_alu_result; l_m2r <= in_mem_to_reg;
        l_rd  <= in_rd;   l_rw  <= in_reg_write;  l_we  <= in_mem_write;
        l_f3  <= in_funct3;
        dmem_req   <= 1'b1;
        dmem_we    <= in_mem_write;
        dmem_addr  <= {in_alu_result[31:2], 2'b00};
        dmem_be    <= be;
        dmem_wdata <= wdata;
        out_valid  <= 1'b0;
      end else if (in_valid) begin
        // Any memory op reaching here is a faulting one.
        out_valid      <= 1'b1;
        out_pc4        <= in_pc4;
        out_alu_result <= in_alu_result;
        out_mem_to_reg <= in_mem_to_reg;
        out_rd         <= in_rd;
        out_mem_data   <= '0;
        out_reg_write  <= in_reg_write & ~mem_op;
        out_misaligned <= mem_op;
        out_timeout    <= 1'b0;
      end else begin
        out_valid <= 1'b0;
      end
    end else if (dmem_ack | expire) begin
      cnt            <= '0;
      dmem_req       <= 1'b0;
      out_valid      <= 1'b1;
      out_pc4        <= l_pc4;
      out_alu_result <= l_alu;
      out_mem_to_reg <= l_m2r;
      out_rd         <= l_rd;
      out_reg_write  <= l_rw & ~expire;
      out_mem_data   <= (dmem_ack & ~l_we) ? load_data : 32'd0;
      out_misaligned <= 1'b0;
      out_timeout    <= expire;
    end else begin
      cnt       <= cnt + 8'd1;
      out_valid <= 1'b0;
    end
  end
endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the 32I pipeline, between execute and write-back. It takes the execute result, runs loads and stores against the data memory over a req/ack handshake, and formats load data (byte/half extraction, sign/zero extension). It registers the operands the write-back mux consumes (pc4, mem_data, alu_result, mem_to_reg) plus rd/reg_write. It stalls upstream while a memory transaction is outstanding.

## Interface
- MAX_WAIT, 16: cycles in BUSY without dmem_ack before the access is abandoned (timeout); range 1..255.

- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  execute-stage result valid this cycle
- in_pc4  in  32  PC+4 of instruction
- in_alu_result  in  32  ALU result; effective address for loads/stores
- in_rs2_data  in  32  store data
- in_mem_read  in  1  instruction is a load
- in_mem_write  in  1  instruction is a store (mem_read and mem_write never both 1)
- in_funct3  in  3  load/store width: 000 B, 001 H, 010 W, 100 BU, 101 HU
- in_mem_to_reg  in  2  write-back select (0 PC4, 1 MEMDATA, 2 ALURESULT), passed through
- in_rd  in  5  destination register
- in_reg_write  in  1  register write enable
- stall  out  1  upstream must hold its inputs this cycle
- dmem_req  out  1  memory request, held until ack
- dmem_we  out  1  1 = write
- dmem_addr  out  32  word address {addr[31:2],2'b00}
- dmem_wdata  out  32  lane-replicated store data
- dmem_be  out  4  byte enables
- dmem_ack  in  1  memory completes request this cycle
- dmem_rdata  in  32  read word, valid with ack
- out_valid  out  1  outputs below valid for write-back
- out_pc4, out_alu_result  out  32 each  registered pass-through
- out_mem_data  out  32  formatted load data; 0 for non-loads
- out_mem_to_reg  out  2  registered pass-through
- out_rd  out  5  registered pass-through
- out_reg_write  out  1  registered; forced 0 on fault/timeout
- out_misaligned  out  1  address misaligned or illegal funct3 for a memory op
- out_timeout  out  1  access abandoned after MAX_WAIT cycles

## Operation
- Memory op = in_valid & (in_mem_read | in_mem_write).
- Fault (misaligned): H/HU/SH with addr[0]=1; W with addr[1:0]≠0; funct3 011/110/111 on any memory op; stores using 100/101.
- FSM states IDLE, BUSY.
- IDLE, non-memory in_valid: register pass-through fields next edge; out_valid=1, out_mem_data=0, flags 0; stall=0.
- IDLE, memory op with fault: no request. Register pass-through fields next edge with out_misaligned=1, out_reg_write=0, out_mem_data=0. stall=0.
- IDLE, legal memory op: stall=1 combinationally. Next edge: go to BUSY and latch the op; dmem_req=1, dmem_addr, dmem_we, dmem_be and dmem_wdata become valid and are held stable; out_valid=0.
- BUSY: stall=~dmem_ack. On an ack cycle, the next edge registers the result with out_valid=1, drops dmem_req, clears the wait counter, and returns to IDLE.
- BUSY timeout: if the wait counter reaches MAX_WAIT without an ack, the next edge drops dmem_req, returns to IDLE, and outputs out_valid=1, out_timeout=1, out_reg_write=0, out_mem_data=0. stall=0 in that final cycle.
- dmem_ack received in IDLE is ignored.
- Byte enables, with off=addr[1:0]:
  - SB: 4'b0001<<off, wdata={4{rs2[7:0]}}
  - SH: 4'b0011<<off, wdata={2{rs2[15:0]}}
  - SW: 4'b1111, wdata=rs2
  - loads: 4'b1111
- Load format: select byte rdata[8*off+:8] or half rdata[16*off[1]+:16]. B/H sign-extend; BU/HU zero-extend; W passes through.
- Stores: out_mem_data=0; the other fields pass through.

## Timing
- Non-memory or faulting op: 1-cycle latency, no stall.
- Load/store: request is visible the cycle after the launch cycle. Output is registered on the edge after the ack cycle. Minimum 2 cycles (ack in the first BUSY cycle); each wait cycle adds 1.
- in_valid=0 with no op in flight: out_valid=0 next edge; payload registers hold.
- Reset (async, mid-transaction included): state=IDLE, dmem_req=0, dmem_we=0, dmem_be=0, dmem_addr=0, dmem_wdata=0, all out_* = 0, stall=0, wait counter=0.

## Test plan
- ALU op, in_alu_result=0x1234, mem_to_reg=2 -> next cycle out_valid=1, out_alu_result=0x1234, out_mem_data=0, stall never 1.
- LB addr 0x103, ack 1st BUSY cycle, rdata=0x80FF_0000 -> dmem_addr=0x100, be=1111; out_mem_data=0xFFFF_FF80, out_valid 2 cycles after launch.
- SH addr 0x22, rs2=0xABCD_5678, ack after 3 wait cycles -> be=1100, wdata=0x5678_5678, we=1; stall high 4 cycles; out_mem_data=0.
- LW addr 0x6 -> no dmem_req; next cycle out_misaligned=1, out_reg_write=0, out_valid=1.
- LHU, no ack, MAX_WAIT=4 -> req for 4 cycles, then out_timeout=1, out_reg_write=0; a later stray ack is ignored.
- rst_n low during BUSY -> dmem_req and all outputs 0 immediately; after release, next load runs normally.
